// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Binary-to-BCD (double dabble) converter feeding a multiplexed,
//            active-low seven-segment scan driver. Optional leading-zero
//            blanking is enabled with macro SEG7_LZ_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int DATA_W         = 16,
    parameter int REFRESH_CYCLES = 100_000
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_W-1:0]     value,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy
);

    localparam int c_BCD_W = 4 * NUM_DIGITS;
    localparam int c_CNT_W = $clog2(DATA_W);
    localparam int c_REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [31:0]        c_LIMIT    = 32'(10 ** NUM_DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0] c_SEG_DASH  = 7'b111_1110;
    localparam logic [6:0] c_SEG_BLANK = 7'b111_1111;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_CONV = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic                  w_start;
    logic                  w_done;

    logic [c_CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]     r_shift;
    logic [c_BCD_W-1:0]    r_bcd;
    logic [c_BCD_W-1:0]    w_bcd_adj;
    logic [c_BCD_W-1:0]    w_bcd_next;
    logic [NUM_DIGITS-1:0] r_cap_dp;
    logic                  r_cap_ovf;

    logic [c_BCD_W-1:0]    r_disp_bcd;
    logic [NUM_DIGITS-1:0] r_disp_dp;
    logic                  r_disp_ovf;

    logic [c_REF_W-1:0]    r_refresh;
    logic [c_IDX_W-1:0]    r_digit;

    logic [3:0]            w_nibble;
    logic [6:0]            w_digit_seg;
    logic                  w_blank;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_an;

    // ------------------------------------------------------------------------
    // Conversion control
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (load) begin
                    w_start      = 1'b1;
                    w_state_next = c_CONV;
                end
            end
            c_CONV: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_done       = 1'b1;
                    w_state_next = c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    assign busy = (r_state == c_CONV);

    // ------------------------------------------------------------------------
    // Double dabble datapath: add 3 to every digit >= 5, then shift in one bit
    // ------------------------------------------------------------------------
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[c_BCD_W-2:0], r_shift[DATA_W-1]};
    end

    // Overflow is decided on the captured operand, so the truncated BCD
    // register never has to hold digits beyond NUM_DIGITS.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_cnt      <= '0;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cap_dp   <= '0;
            r_cap_ovf  <= 1'b0;
            r_disp_bcd <= '0;
            r_disp_dp  <= '0;
            r_disp_ovf <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= '0;
            r_shift   <= value;
            r_bcd     <= '0;
            r_cap_dp  <= dp_mask;
            r_cap_ovf <= (32'(value) >= c_LIMIT);
        end else if (busy) begin
            r_cnt   <= r_cnt + c_CNT_W'(1);
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            r_bcd   <= w_bcd_next;
            if (w_done) begin
                r_disp_bcd <= w_bcd_next;
                r_disp_dp  <= r_cap_dp;
                r_disp_ovf <= r_cap_ovf;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Free-running digit scan
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_refresh <= '0;
            r_digit   <= '0;
        end else if (r_refresh == c_REF_LAST) begin
            r_refresh <= '0;
            r_digit   <= (r_digit == c_IDX_LAST) ? '0 : r_digit + c_IDX_W'(1);
        end else begin
            r_refresh <= r_refresh + c_REF_W'(1);
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] w_upper_nz;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        assign w_upper_nz[i] = |r_disp_bcd[c_BCD_W-1:4*i];
    end

    // Digit 0 is never blanked so a zero value still shows one "0".
    assign w_blank = (r_digit != '0) && !w_upper_nz[r_digit];
`else
    assign w_blank = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_nibble = r_disp_bcd[4*int'(r_digit) +: 4];
        w_an     = '1;
        w_an[r_digit] = 1'b0;

        case (w_nibble)
            4'd0:    w_digit_seg = 7'b000_0001;
            4'd1:    w_digit_seg = 7'b100_1111;
            4'd2:    w_digit_seg = 7'b001_0010;
            4'd3:    w_digit_seg = 7'b000_0110;
            4'd4:    w_digit_seg = 7'b100_1100;
            4'd5:    w_digit_seg = 7'b010_0100;
            4'd6:    w_digit_seg = 7'b010_0000;
            4'd7:    w_digit_seg = 7'b000_1111;
            4'd8:    w_digit_seg = 7'b000_0000;
            4'd9:    w_digit_seg = 7'b000_0100;
            default: w_digit_seg = c_SEG_DASH;
        endcase

        if (r_disp_ovf) begin
            w_seg = c_SEG_DASH;
            w_dp  = 1'b1;
        end else if (w_blank) begin
            w_seg = c_SEG_BLANK;
            w_dp  = 1'b1;
        end else begin
            w_seg = w_digit_seg;
            w_dp  = ~r_disp_dp[r_digit];
        end
    end

    assign seg = w_seg;
    assign dp  = w_dp;
    assign an  = w_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed self-checking bench for seg7_scan_driver
//            (NUM_DIGITS=4, DATA_W=16, REFRESH_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam logic [6:0] S0   = 7'b000_0001;
    localparam logic [6:0] S1   = 7'b100_1111;
    localparam logic [6:0] S2   = 7'b001_0010;
    localparam logic [6:0] S3   = 7'b000_0110;
    localparam logic [6:0] S4   = 7'b100_1100;
    localparam logic [6:0] S5   = 7'b010_0100;
    localparam logic [6:0] S7   = 7'b000_1111;
    localparam logic [6:0] S8   = 7'b000_0000;
    localparam logic [6:0] DASH = 7'b111_1110;
`ifdef SEG7_LZ_BLANK_EN
    localparam logic [6:0] LZ   = 7'b111_1111;
`else
    localparam logic [6:0] LZ   = S0;
`endif

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];

    seg7_scan_driver #(
        .NUM_DIGITS     (4),
        .DATA_W         (16),
        .REFRESH_CYCLES (4)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .load       (load),
        .value      (value),
        .dp_mask    (dp_mask),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .busy       (busy)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Step one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_100MHz);
        #1;
        cyc++;
    endtask

    task automatic set_exp(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                           input logic [6:0] s0, input logic [3:0] dps);
        exp_seg[3] = s3; exp_seg[2] = s2; exp_seg[1] = s1; exp_seg[0] = s0;
        for (int i = 0; i < 4; i++) exp_dp[i] = dps[i];
    endtask

    // Scan position is modelled from the cycle count since reset release.
    task automatic check_scan(input string tag, input int n);
        logic [3:0] exp_an;
        int idx;
        for (int k = 0; k < n; k++) begin
            idx    = (cyc / 4) % 4;
            exp_an = 4'b1111;
            exp_an[idx] = 1'b0;
            check($sformatf("%s_an_c%0d", tag, cyc), 16'(an), 16'(exp_an));
            check($sformatf("%s_seg_d%0d", tag, idx), 16'(seg), 16'(exp_seg[idx]));
            check($sformatf("%s_dp_d%0d", tag, idx), 16'(dp), 16'(exp_dp[idx]));
            tick();
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 40) begin
            tick();
            k++;
        end
        check($sformatf("%s_idle", tag), 16'(busy), 16'd0);
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        value   = '0;
        dp_mask = '0;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;

        // Reset state and scan sequence, including wrap back to digit 0
        check("rst_busy", 16'(busy), 16'd0);
        set_exp(LZ, LZ, LZ, S0, 4'b1111);
        check_scan("scan", 17);

        // 1234 with decimal point on digit 2; busy exactly 16 cycles
        value = 16'd1234; dp_mask = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0; value = '0; dp_mask = '0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("b1234_busy_%0d", i), 16'(busy), 16'd1);
            tick();
        end
        check("b1234_busy_end", 16'(busy), 16'd0);
        set_exp(S1, S2, S3, S4, 4'b1011);
        check_scan("v1234", 16);

        // 7 with load held through the whole conversion; operands change meanwhile
        value = 16'd7; dp_mask = 4'b0000; load = 1'b1;
        tick();
        value = 16'd9; dp_mask = 4'b1111;
        repeat (16) tick();
        load = 1'b0;
        check("v7_busy_end", 16'(busy), 16'd0);
        set_exp(LZ, LZ, LZ, S7, 4'b1111);
        check_scan("v7", 16);

        // Overflow: 10000 on four digits, dp requested but forced off
        value = 16'd10000; dp_mask = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        wait_idle("ovf");
        set_exp(DASH, DASH, DASH, DASH, 4'b1111);
        check_scan("ovf", 16);

        // Reset five cycles into a conversion of 9999
        value = 16'd9999; dp_mask = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
        check("abort_busy", 16'(busy), 16'd0);
        set_exp(LZ, LZ, LZ, S0, 4'b1111);
        check_scan("abort", 24);

        // Back-to-back: 42, then 58 loaded in the cycle busy falls
        value = 16'd42; dp_mask = 4'b0000; load = 1'b1;
        tick();
        load = 1'b0;
        wait_idle("b42");
        value = 16'd58; load = 1'b1;
        tick();
        load = 1'b0;
        check("b58_busy", 16'(busy), 16'd1);
        set_exp(LZ, LZ, S4, S2, 4'b1111);
        check_scan("hold42", 16);
        check("b58_busy_end", 16'(busy), 16'd0);
        set_exp(LZ, LZ, S5, S8, 4'b1111);
        check_scan("v58", 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
